sort_loader: RTL and testbench
==============================

Name: sort_loader

Overview:
- Front-end stage that sits upstream of the in-memory sort controller and shares the same 8x8 word memory bus.
- Accepts DEPTH bytes from a valid/ready input stream and writes them into memory.
- Pulses start to the sort controller, hands the bus over, and waits for its done pulse.
- Takes the bus back, reads all words from address 0 upward and emits them on a valid/ready output stream.

Parameters:
- DW, 8, data word width.
- AW, 3, memory address width.
- DEPTH, 8, words per sort batch; must equal 2**AW.
- STRB_CYC, 3, strobe cycles per memory access, matching the controller's access timing.
- TIMEOUT_CYC, 2048, watchdog limit in cycles (used only with SORT_TIMEOUT_EN).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, reset: asynchronous, active-high.
- in_data, input, DW, input byte.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, loader accepts in_data this cycle.
- out_data, output, DW, sorted byte.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- mem_add, output, AW, memory address (registered).
- mem_wr, output, 1, memory write strobe, active-low.
- mem_data, inout, DW, shared memory data bus.
- bus_sel, output, 1, 1 = loader owns the memory bus, 0 = sort controller owns it (drives the external bus mux).
- sort_start, output, 1, one-cycle start pulse to the controller.
- sort_done, input, 1, one-cycle done pulse from the controller.
- busy, output, 1, high in every state except IDLE.
- err, output, 1, sticky timeout flag (constant 0 without SORT_TIMEOUT_EN).

Behaviour:
- Reset values:
  - State = IDLE; word index idx = 0; strobe counter = 0.
  - mem_add = 0, mem_wr = 1, mem_data = Z, bus_sel = 1.
  - sort_start = 0, in_ready = 0, out_valid = 0, out_data = 0, busy = 0, err = 0.
- Reset mid-operation aborts immediately: the bus is released (Z), and any partial batch is discarded.
- State machine:
  - IDLE: in_ready = 1. On in_valid, capture in_data into a holding register, set idx = 0, go to WR_SETUP. There is no separate start input; the first byte starts a batch.
  - LD_WAIT: in_ready = 1. On in_valid, capture the byte and go to WR_SETUP.
  - WR_SETUP (1 cycle): mem_add <= idx.
  - WR_STRB (STRB_CYC cycles): mem_wr = 0 and mem_data driven with the held byte on exactly these cycles.
    - Last strobe cycle with idx == DEPTH-1: go to KICK.
    - Otherwise: idx++ and go to LD_WAIT.
  - KICK (1 cycle): sort_start = 1, bus_sel = 0, mem_data = Z. Go to SORT_WAIT.
  - SORT_WAIT: bus_sel = 0, mem_wr = 1, mem_data = Z. On sort_done, set idx = 0 and go to RD_SETUP.
  - RD_SETUP (1 cycle): bus_sel = 1, mem_add <= idx.
  - RD_STRB (STRB_CYC cycles): mem_wr = 1, mem_data = Z. On the last strobe cycle, register mem_data into out_data, set out_valid = 1 and go to OUT.
  - OUT: hold out_data and out_valid until out_ready.
    - On the out_valid & out_ready handshake with idx == DEPTH-1: go to IDLE.
    - Otherwise: idx++ and go to RD_SETUP.
- in_ready is 0 in all states other than IDLE and LD_WAIT; bytes offered then are not consumed.
- Stall/backpressure:
  - in_valid low in LD_WAIT waits indefinitely.
  - out_ready low in OUT holds indefinitely; out_data must be stable while stalled.
- sort_done arriving outside SORT_WAIT is ignored.
- A 1-cycle sort_done pulse must never be missed in SORT_WAIT.
- The loader drives mem_data only in WR_STRB; it must never drive the bus while bus_sel = 0.
- idx is AW bits wide; its wrap from DEPTH-1 to 0 is never used, because the transitions above terminate first.
- Latency figures:
  - Per write: 1 + STRB_CYC cycles.
  - Per read to out_valid: 1 + STRB_CYC cycles.
  - Last write strobe to sort_start: 1 cycle.

Optional Feature:
- Macro: SORT_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in SORT_WAIT and clears on entry.
  - If it reaches TIMEOUT_CYC without sort_done: set err = 1 (sticky until rst), set bus_sel = 1, go to IDLE, and produce no output.
  - Any in-flight sort_done after the timeout is ignored.
- When undefined: there is no counter, err is tied to 0, and SORT_WAIT waits forever.

Test Plan:
- Reset values: assert rst mid-WR_STRB, e.g. at the third byte. Required: mem_wr = 1, mem_data = Z, bus_sel = 1, busy = 0 at once; a fresh 8-byte load afterwards completes normally.
- Full batch with behavioural memory plus a stub sorter that reverses the memory: stream 01..08 with in_valid always high. Required:
  - 8 writes to addresses 0..7, each with mem_wr low for exactly 3 cycles.
  - Exactly one sort_start pulse.
  - Outputs 08,07,...,01.
- Integration with the real sort controller and memory: load 07,05,03,01,08,06,04,02. Required: out stream 08,07,06,05,04,03,02,01 (descending); bus_sel = 0 exactly from KICK until sort_done.
- Gapped input: in_valid low for 5 cycles between each byte. Required: bytes land at the correct addresses; in_ready = 0 during strobes; no byte is dropped or duplicated.
- Output backpressure: out_ready low for 10 cycles on word 3. Required: out_data stays stable and out_valid stays high; the next read starts only after the handshake.
- SORT_TIMEOUT_EN with TIMEOUT_CYC = 16 and a stub that never pulses sort_done. Required: err = 1 sixteen cycles after entering SORT_WAIT, state returns to IDLE, out_valid is never asserted.

Source files
------------

// File: rtl/sort_loader.sv
// -----------------------------------------------------------------------------
// sort_loader
//
// Front-end stage for the in-memory sort controller. Both blocks share one
// 8x8 word memory bus. The loader:
//   1. accepts DEPTH bytes from a valid/ready input stream and writes them to
//      memory addresses 0..DEPTH-1,
//   2. pulses sort_start, hands the bus to the controller (bus_sel = 0) and
//      waits for its sort_done pulse,
//   3. takes the bus back, reads addresses 0..DEPTH-1 and emits each word on
//      a valid/ready output stream.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds data and valid stable
// until that edge; the loader never makes its ready/valid wait on the other
// side's ready/valid within the same cycle.
//
// Optional feature: define SORT_TIMEOUT_EN to add a SORT_WAIT watchdog. After
// TIMEOUT_CYC cycles without sort_done the loader sets a sticky err, takes
// the bus back and returns to IDLE without producing output. Without the
// macro err is tied to 0 and SORT_WAIT waits forever.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_data/in_valid    input byte stream; in_ready is the loader's ready
//   out_data/out_valid  sorted output stream; out_ready from downstream
//   mem_add             registered memory address
//   mem_wr              memory write strobe, active low
//   mem_data            shared bidirectional memory data bus
//   bus_sel             1 = loader owns the bus, 0 = sort controller owns it
//   sort_start          one-cycle start pulse to the controller
//   sort_done           one-cycle done pulse from the controller
//   busy                high in every state except IDLE
//   err                 sticky watchdog flag
//   dbg_state           current FSM state encoding, for debug and checkers
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sort_loader #(
  parameter int DW          = 8,
  parameter int AW          = 3,
  parameter int DEPTH       = 8,
  parameter int STRB_CYC    = 3,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] mem_add,
  output logic          mem_wr,
  inout  wire  [DW-1:0] mem_data,
  output logic          bus_sel,
  output logic          sort_start,
  input  logic          sort_done,
  output logic          busy,
  output logic          err,
  output logic [3:0]    dbg_state
);

  localparam int SW = (STRB_CYC > 1) ? $clog2(STRB_CYC) : 1;
  localparam logic [SW-1:0] STRB_LAST = SW'(STRB_CYC - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LD_WAIT   = 4'd1,
    WR_SETUP  = 4'd2,
    WR_STRB   = 4'd3,
    KICK      = 4'd4,
    SORT_WAIT = 4'd5,
    RD_SETUP  = 4'd6,
    RD_STRB   = 4'd7,
    OUT       = 4'd8
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_idx;
  logic [SW-1:0] r_strb;
  logic [DW-1:0] r_hold;
  logic [AW-1:0] r_mem_add;
  logic [DW-1:0] r_out_data;

  logic w_in_ready;
  logic w_drive;
  logic w_mem_wr;
  logic w_bus_sel;
  logic w_start;
  logic w_out_valid;
  logic w_last_strb;
  logic w_last_idx;
  logic w_timeout;

  assign w_last_strb = (r_strb == STRB_LAST);
  assign w_last_idx  = (r_idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Optional SORT_WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef SORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_tmr;
  logic          r_err;

  // A done pulse on the final watchdog cycle still wins over the timeout.
  assign w_timeout = (r_state == SORT_WAIT) && !sort_done && (r_tmr == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == KICK) begin
        r_tmr <= '0;
      end else if (r_state == SORT_WAIT && !sort_done) begin
        r_tmr <= r_tmr + TW'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
  // Keeps the watchdog limit referenced in builds without the watchdog.
  wire w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_drive     = 1'b0;
    w_mem_wr    = 1'b1;
    w_bus_sel   = 1'b1;
    w_start     = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE, LD_WAIT: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = WR_SETUP;
      end
      WR_SETUP: begin
        w_next = WR_STRB;
      end
      WR_STRB: begin
        w_mem_wr = 1'b0;
        w_drive  = 1'b1;
        if (w_last_strb) w_next = w_last_idx ? KICK : LD_WAIT;
      end
      KICK: begin
        w_start   = 1'b1;
        w_bus_sel = 1'b0;
        w_next    = SORT_WAIT;
      end
      SORT_WAIT: begin
        w_bus_sel = 1'b0;
        if (sort_done)      w_next = RD_SETUP;
        else if (w_timeout) w_next = IDLE;
      end
      RD_SETUP: begin
        w_next = RD_STRB;
      end
      RD_STRB: begin
        if (w_last_strb) w_next = OUT;
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next = w_last_idx ? IDLE : RD_SETUP;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: word index, strobe counter, holding byte, address, output word
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_strb     <= '0;
      r_hold     <= '0;
      r_mem_add  <= '0;
      r_out_data <= '0;
    end else begin
      // Strobe counter only runs inside a strobe phase and is zero otherwise.
      if ((r_state == WR_STRB || r_state == RD_STRB) && !w_last_strb) begin
        r_strb <= r_strb + SW'(1);
      end else begin
        r_strb <= '0;
      end
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_hold <= in_data;
            r_idx  <= '0;
          end
        end
        LD_WAIT: begin
          if (in_valid) r_hold <= in_data;
        end
        WR_SETUP, RD_SETUP: begin
          r_mem_add <= r_idx;
        end
        WR_STRB: begin
          if (w_last_strb && !w_last_idx) r_idx <= r_idx + AW'(1);
        end
        SORT_WAIT: begin
          if (sort_done) r_idx <= '0;
        end
        RD_STRB: begin
          if (w_last_strb) r_out_data <= mem_data;
        end
        OUT: begin
          if (out_ready && !w_last_idx) r_idx <= r_idx + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // in_ready is held low while reset is asserted even though the state is IDLE.
  assign in_ready   = w_in_ready & ~rst;
  assign out_valid  = w_out_valid;
  assign out_data   = r_out_data;
  assign mem_add    = r_mem_add;
  assign mem_wr     = w_mem_wr;
  assign bus_sel    = w_bus_sel;
  assign sort_start = w_start;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

  // The bus is driven only during write strobes, which always have bus_sel = 1.
  assign mem_data = w_drive ? r_hold : {DW{1'bz}};

endmodule

// File: tb/tb_sort_loader.sv
`timescale 1ns/1ps

module tb_sort_loader;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int TMO = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          stub_done = 1'b0;
  logic          stray_done = 1'b0;
  wire           sort_done = stub_done | stray_done;
  wire           in_ready;
  wire  [DW-1:0] out_data;
  wire           out_valid;
  wire  [AW-1:0] mem_add;
  wire           mem_wr;
  wire  [DW-1:0] mem_data;
  wire           bus_sel;
  wire           sort_start;
  wire           busy;
  wire           err;
  wire  [3:0]    dbg_state;

  always #5 clk = ~clk;

  sort_loader #(
    .DW(DW), .AW(AW), .DEPTH(8), .STRB_CYC(3), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_add(mem_add), .mem_wr(mem_wr), .mem_data(mem_data),
    .bus_sel(bus_sel), .sort_start(sort_start), .sort_done(sort_done),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memory + sorter stub (environment)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [0:7];
  logic          mem_oe = 1'b0;
  int            stub_mode = 1;   // 0 = reverse memory, 1 = sort descending, 2 = never done
  int            stub_delay = 3;  // cycles from sort_start to sort_done, >= 2
  int            stub_cnt = 0;
  logic          stub_armed = 1'b0;
  logic [DW-1:0] sq[$];
  logic [DW-1:0] tmp;

  // Memory answers reads whenever the loader owns the bus and is not writing.
  assign mem_data = (mem_oe && bus_sel && mem_wr) ? mem[mem_add] : 8'hzz;

  // Monitor state (owned by the monitor process only)
  int            wr_run = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_len_q[$];
  int            start_cnt = 0, bsel_low = 0, z_viol = 0, rdy_viol = 0, ov_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      wr_run     = 0;
      stub_armed = 1'b0;
      stub_done  = 1'b0;
    end else begin
      if (mem_wr === 1'b0) begin
        if (wr_run == 0) begin
          wr_addr_q.push_back(mem_add);
          wr_data_q.push_back(mem_data);
        end
        mem[mem_add] = mem_data;
        wr_run++;
      end else if (wr_run != 0) begin
        wr_len_q.push_back(wr_run);
        wr_run = 0;
      end
      if (bus_sel === 1'b0) begin
        bsel_low++;
        if (!(mem_data === 8'hzz)) z_viol++;
      end
      if (mem_wr === 1'b0 && in_ready === 1'b1) rdy_viol++;
      if (out_valid === 1'b1) ov_cnt++;
      if (sort_start === 1'b1) begin
        start_cnt++;
        if (stub_mode == 0) begin
          for (int i = 0; i < 4; i++) begin
            tmp = mem[i]; mem[i] = mem[7-i]; mem[7-i] = tmp;
          end
        end else if (stub_mode == 1) begin
          sq.delete();
          for (int i = 0; i < 8; i++) sq.push_back(mem[i]);
          sq.rsort();
          for (int i = 0; i < 8; i++) mem[i] = sq[i];
        end
        if (stub_mode != 2) begin
          stub_cnt   = stub_delay - 1;
          stub_armed = 1'b1;
        end
      end else if (stub_armed) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_done  = 1'b1;
          stub_armed = 1'b0;
        end
      end else begin
        stub_done = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] in_b [8];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [DW-1:0] b);
    int cyc = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_accept_wait", (cyc < 200), 1);
    @(negedge clk);
  endtask

  task automatic recv_word(input int stall);
    int            cyc = 0;
    logic          ok;
    logic [DW-1:0] d0;
    logic [AW-1:0] a0;
    logic [DW-1:0] e;
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_wait", (cyc < 200), 1);
    if (stall > 0) begin
      ok = 1'b1;
      d0 = out_data;
      a0 = mem_add;
      repeat (stall) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== d0 || mem_add !== a0) ok = 1'b0;
      end
      chk("stall_hold", ok, 1);
      out_ready = 1'b1;
    end
    chk("exp_q_nonempty", (exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk("out_data", out_data, e);
    @(negedge clk);
  endtask

  // One full batch from in_b; expected stream from the stub's rule on the input list.
  task automatic run_batch(input int mode, input int gap, input int stall_word, input int stall_len);
    logic [DW-1:0] q[$];
    int ab, lb, s0, b0, z0, r0, lenbad;
    ab = wr_addr_q.size(); lb = wr_len_q.size();
    s0 = start_cnt; b0 = bsel_low; z0 = z_viol; r0 = rdy_viol;
    stub_mode  = mode;
    stub_delay = $urandom_range(2, 6);
    exp_q.delete();
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(in_b[i]);
    if (mode == 0) q.reverse();
    else q.rsort();
    for (int i = 0; i < 8; i++) exp_q.push_back(q[i]);
    for (int i = 0; i < 8; i++) begin
      send_byte(in_b[i]);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    for (int w = 0; w < 8; w++) recv_word((w == stall_word) ? stall_len : 0);
    @(negedge clk);
    chk("wr_count", wr_len_q.size() - lb, 8);
    lenbad = 0;
    for (int i = lb; i < wr_len_q.size(); i++) if (wr_len_q[i] != 3) lenbad++;
    chk("wr_strobe_len", lenbad, 0);
    for (int i = 0; i < 8; i++) begin
      chk("wr_addr", (ab + i < wr_addr_q.size()) ? wr_addr_q[ab+i] : 3'h0, i);
      chk("wr_data", (ab + i < wr_data_q.size()) ? wr_data_q[ab+i] : 8'h00, in_b[i]);
    end
    chk("sort_start_pulses", start_cnt - s0, 1);
    chk("bus_sel_low_cycles", bsel_low - b0, stub_delay);
    chk("bus_driven_while_released", z_viol - z0, 0);
    chk("in_ready_during_strobe", rdy_viol - r0, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("busy_after_batch", busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic z_ok;
    int   cyc;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset values, with memory output disabled so the bus floats.
    repeat (3) @(negedge clk);
    z_ok = (mem_data === 8'hzz);
    chk("rst_mem_data_z", z_ok, 1);
    chk("rst_mem_wr", mem_wr, 1);
    chk("rst_bus_sel", bus_sel, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mem_add", mem_add, 0);
    chk("rst_sort_start", sort_start, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    mem_oe = 1'b1;

    // Stray sort_done in IDLE is ignored.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    chk("stray_done_idle_busy", busy, 0);
    @(negedge clk);
    chk("stray_done_idle_start", sort_start, 0);

    // Reset in the middle of the third byte's write strobe.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    in_valid = 1'b0;
    @(negedge clk);
    chk("strobe_before_rst", mem_wr, 0);
    mem_oe = 1'b0;
    rst    = 1'b1;
    #1;
    z_ok = (mem_data === 8'hzz);
    chk("midrst_mem_wr", mem_wr, 1);
    chk("midrst_mem_data_z", z_ok, 1);
    chk("midrst_bus_sel", bus_sel, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst    = 1'b0;
    mem_oe = 1'b1;
    @(negedge clk);

    // Stub reverses memory: 01..08 in, 08..01 out.
    for (int i = 0; i < 8; i++) in_b[i] = 8'(i + 1);
    run_batch(0, 0, 8, 0);

    // Stub sorts memory descending.
    in_b = '{8'h07, 8'h05, 8'h03, 8'h01, 8'h08, 8'h06, 8'h04, 8'h02};
    run_batch(1, 0, 8, 0);

    // Gapped input and a 10-cycle output stall on word 3.
    for (int i = 0; i < 8; i++) in_b[i] = 8'($urandom);
    run_batch(1, 5, 3, 10);

    // Randomized batches.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) in_b[i] = 8'($urandom);
      run_batch($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 6));
    end

`ifdef SORT_TIMEOUT_EN
    begin
      int ov0;
      stub_mode = 2;
      for (int i = 0; i < 8; i++) begin
        in_b[i] = 8'($urandom);
        send_byte(in_b[i]);
      end
      in_valid = 1'b0;
      cyc = 0;
      while (sort_start !== 1'b1 && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      chk("tmo_kick_seen", (cyc < 300), 1);
      ov0 = ov_cnt;
      repeat (TMO) @(negedge clk);
      chk("tmo_err_before", err, 0);
      chk("tmo_busy_before", busy, 1);
      @(negedge clk);
      chk("tmo_err_set", err, 1);
      chk("tmo_idle", busy, 0);
      chk("tmo_bus_sel", bus_sel, 1);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      chk("tmo_late_done_ignored", busy, 0);
      repeat (20) @(negedge clk);
      chk("tmo_no_output", ov_cnt - ov0, 0);
      chk("tmo_err_sticky", err, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("tmo_err_cleared", err, 0);
      rst = 1'b0;
      @(negedge clk);
    end
`else
    chk("err_tied_low", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    bad++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
